idli_ctrl_seq_m: RTL
====================

IDLI_CTRL_SEQ_M -- requirements
Module: idli_ctrl_seq_m

Interface
- REQ-001 SHALL have parameter BEATS, default 4: beats (cycles) per serial word; legal range 2..16, not restricted to powers of two.
- REQ-002 SHALL have parameter WORDS_W, default 2: width of the word count; an instruction is 1..2**WORDS_W words.
- REQ-003 SHALL derive CTR_W = max(1, $clog2(BEATS)) as a localparam.
- REQ-004 i_ctrlseq_gck  in  1  sole clock, rising edge.
- REQ-005 i_ctrlseq_rst  in  1  reset, asynchronous, active-high.
- REQ-006 i_ctrlseq_stall  in  1  hold beat counter, word counter and state.
- REQ-007 i_ctrlseq_flush  in  1  abort current instruction; return to IDLE.
- REQ-008 i_ctrlseq_start  in  1  request a new instruction.
- REQ-009 i_ctrlseq_words  in  WORDS_W  extra words after the first (0 = single-word).
- REQ-010 o_ctrlseq_ctr  out  CTR_W  current beat, 0..BEATS-1.
- REQ-011 o_ctrlseq_first_beat  out  1  ctr == 0.
- REQ-012 o_ctrlseq_last_beat  out  1  ctr == BEATS-1.
- REQ-013 o_ctrlseq_word  out  WORDS_W  current word index within the instruction.
- REQ-014 o_ctrlseq_last_word  out  1  busy and word == latched word count.
- REQ-015 o_ctrlseq_busy  out  1  state == RUN.
- REQ-016 o_ctrlseq_done  out  1  single-cycle pulse on the final beat of the final word.

Function
- REQ-017 Beat counter SHALL increment by 1 each cycle without stall and wrap from BEATS-1 to 0; it runs in IDLE and RUN to keep serial alignment.
- REQ-018 Flush SHALL NOT alter the beat counter; only reset clears it.
- REQ-019 FSM states SHALL be IDLE and RUN.
- REQ-020 IDLE->RUN SHALL occur only on a cycle with start=1, last_beat=1, stall=0 and flush=0; i_ctrlseq_words is latched and word set to 0, so the instruction begins at beat 0.
- REQ-021 In IDLE, start on a non-last beat SHALL be ignored; the requester holds start until accepted.
- REQ-022 In RUN, on last_beat without stall, word SHALL increment if word != latched count.
- REQ-023 In RUN, on last_beat of the last word without stall, done SHALL be 1 that cycle; the next state is IDLE with word 0, unless start=1, in which case the block stays in RUN, reloads the count and sets word to 0 (back-to-back, no bubble).
- REQ-024 done SHALL be combinational: busy & last_beat & last_word & !stall & !flush.
- REQ-025 Stall SHALL freeze all state; outputs hold their values and done is 0.
- REQ-026 Flush SHALL take priority over stall and start: next state IDLE, word 0, latched count 0, no done.
- REQ-027 Word count WORDS_W'(2**WORDS_W - 1) SHALL be legal; the word counter never wraps within an instruction.
- REQ-028 first_beat and last_beat SHALL be pure decodes of the beat counter, valid in both states.

Reset
- REQ-029 Reset assertion SHALL asynchronously force ctr=0, word=0, latched count=0 and state IDLE, so that busy=0, done=0, last_word=0, first_beat=1 and last_beat=0.
- REQ-030 Reset mid-instruction SHALL abandon it with no done pulse; after release, counting resumes from beat 0 on the first clock edge.

Structure
- REQ-031 The state enum typedef (IDLE, RUN) and the default BEATS constant SHALL live in idli_pkg.
- REQ-032 SHALL instantiate the sub-module idli_wrap_ctr_m (parametrised width, wrap value, enable, clear) twice: beat counter and word counter.
- REQ-033 All flops SHALL be in the gck/rst domain; no other clocks and no latches.

Verification
- REQ-034 BEATS=4, no start: ctr sequence 0,1,2,3,0 after reset release; last_beat high only at 3; busy=0.
- REQ-035 BEATS=5: ctr wraps 4->0, never reaches 5-7; last_beat at 4.
- REQ-036 BEATS=4, words=2, start held from beat 1: accepted at beat 3; word 0,1,2 over 12 cycles; done pulses once, at word 2 beat 3; then busy=0.
- REQ-037 Back-to-back: start=1 with words=0 during the done cycle: busy stays 1, word=0, second done exactly 4 cycles later.
- REQ-038 Stall for 3 cycles at word 1 beat 2: ctr/word frozen; done delayed by exactly 3 cycles; stall asserted on the done beat suppresses done.
- REQ-039 Flush with stall at word 1 beat 1: next cycle IDLE, word 0, ctr 2, no done; async reset mid-RUN: all outputs at reset values before the next edge.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the serial control sequencer.
package idli_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_BEATS = 4;

    // Beat counter width; a 2-beat word still needs one bit.
    function automatic int ctr_width(input int beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/idli_wrap_ctr_m.sv
// Wrapping up-counter with clear (priority) and enable; async active-high reset.
module idli_wrap_ctr_m #(
    parameter int W    = 2,
    parameter int WRAP = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == W'(WRAP)) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/idli_ctrl_seq_m.sv
// Serial instruction sequencer: free-running beat counter plus word counter
// stepping through a 1..2**WORDS_W word instruction, with stall and flush.
module idli_ctrl_seq_m
    import idli_pkg::*;
#(
    parameter int BEATS   = DEFAULT_BEATS,
    parameter int WORDS_W = 2
) (
    input  logic                          i_ctrlseq_gck,
    input  logic                          i_ctrlseq_rst,
    input  logic                          i_ctrlseq_stall,
    input  logic                          i_ctrlseq_flush,
    input  logic                          i_ctrlseq_start,
    input  logic [WORDS_W-1:0]            i_ctrlseq_words,
    output logic [ctr_width(BEATS)-1:0]   o_ctrlseq_ctr,
    output logic                          o_ctrlseq_first_beat,
    output logic                          o_ctrlseq_last_beat,
    output logic [WORDS_W-1:0]            o_ctrlseq_word,
    output logic                          o_ctrlseq_last_word,
    output logic                          o_ctrlseq_busy,
    output logic                          o_ctrlseq_done
);

    localparam int CTR_W = ctr_width(BEATS);

    state_e               state_reg, state_next;
    logic [WORDS_W-1:0]   count_reg, count_next;
    logic [CTR_W-1:0]     ctr;
    logic [WORDS_W-1:0]   word;
    logic                 busy, last_beat, last_word, done;
    logic                 accept, restart, beat_en, word_en, word_clr;

    assign busy      = (state_reg == RUN);
    assign last_beat = (ctr == CTR_W'(BEATS - 1));
    assign last_word = busy && (word == count_reg);
    assign done      = busy && last_beat && last_word && !i_ctrlseq_stall && !i_ctrlseq_flush;

    // New instructions only launch on the last beat so they start at beat 0.
    assign accept  = !busy && i_ctrlseq_start && last_beat && !i_ctrlseq_stall && !i_ctrlseq_flush;
    assign restart = done && i_ctrlseq_start;

    // Flush overrides stall, so the beat counter keeps serial alignment.
    assign beat_en  = !i_ctrlseq_stall || i_ctrlseq_flush;
    assign word_en  = busy && last_beat && !last_word && !i_ctrlseq_stall && !i_ctrlseq_flush;
    assign word_clr = i_ctrlseq_flush || accept || done;

    idli_wrap_ctr_m #(
        .W    (CTR_W),
        .WRAP (BEATS - 1)
    ) u_beat_ctr (
        .clk (i_ctrlseq_gck),
        .rst (i_ctrlseq_rst),
        .en  (beat_en),
        .clr (1'b0),
        .cnt (ctr)
    );

    idli_wrap_ctr_m #(
        .W    (WORDS_W),
        .WRAP ((1 << WORDS_W) - 1)
    ) u_word_ctr (
        .clk (i_ctrlseq_gck),
        .rst (i_ctrlseq_rst),
        .en  (word_en),
        .clr (word_clr),
        .cnt (word)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (i_ctrlseq_flush) begin
            state_next = IDLE;
            count_next = '0;
        end else if (accept || restart) begin
            state_next = RUN;
            count_next = i_ctrlseq_words;
        end else if (done) begin
            state_next = IDLE;
            count_next = '0;
        end
    end

    always_ff @(posedge i_ctrlseq_gck or posedge i_ctrlseq_rst) begin
        if (i_ctrlseq_rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    assign o_ctrlseq_ctr        = ctr;
    assign o_ctrlseq_first_beat = (ctr == '0);
    assign o_ctrlseq_last_beat  = last_beat;
    assign o_ctrlseq_word       = word;
    assign o_ctrlseq_last_word  = last_word;
    assign o_ctrlseq_busy       = busy;
    assign o_ctrlseq_done       = done;

endmodule
